// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the SimpleRisc MA-stage data-memory responder:
// FSM encoding, wait-counter sizing and the access-legality check.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int CNT_W           = 4;
    localparam int WORD_OFFSET     = 2;
    localparam int DEPTH_WORDS_DEF = 1024;

    // Misaligned or beyond the last stored word.
    function automatic logic addrErr(input logic [31:0] addr, input logic [31:0] depthWords);
        return (addr[WORD_OFFSET-1:0] != '0) || ((addr >> WORD_OFFSET) >= depthWords);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response valid-ready channels between the MA stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// Word storage for the responder: synchronous write, combinational read,
// contents deliberately survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// error response for misaligned or out-of-range addresses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    dmem_responder_if.slave  bus,
    output logic             busy_o
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               accept;
    logic               memWe;
    logic               accErr;
    logic [31:0]        memRdata;

    assign accErr = addrErr(addr_q, 32'(DEPTH_WORDS));

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (memWe),
        .addr_i  (addr_q[WORD_OFFSET +: AW]),
        .wdata_i (wdata_q),
        .rdata_o (memRdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        accept  = 1'b0;
        memWe   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Access edge: the store commits and the load data is captured together.
                    state_d = ST_RESP;
                    err_d   = accErr;
                    memWe   = write_q && !accErr;
                    rdata_d = (accErr || write_q) ? 32'h0 : memRdata;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (0 and 2 wait states) checked every
// cycle against a transaction-level model, plus hand-computed directed checks.
module tb_dmem_responder;

    logic clk;
    logic rst_n;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    logic        reqValid  [2];
    logic        reqWrite  [2];
    logic [31:0] reqAddr   [2];
    logic [31:0] reqWdata  [2];
    logic        rspReady  [2];
    logic        reqReady  [2];
    logic        rspValid  [2];
    logic [31:0] rspRdata  [2];
    logic        rspErr    [2];
    logic        busyOut   [2];
    logic        busy0, busy1;

    int compareCount = 0;
    int mismatchCount = 0;

    assign bus0.req_valid = reqValid[0];
    assign bus0.req_write = reqWrite[0];
    assign bus0.req_addr  = reqAddr[0];
    assign bus0.req_wdata = reqWdata[0];
    assign bus0.rsp_ready = rspReady[0];
    assign bus1.req_valid = reqValid[1];
    assign bus1.req_write = reqWrite[1];
    assign bus1.req_addr  = reqAddr[1];
    assign bus1.req_wdata = reqWdata[1];
    assign bus1.rsp_ready = rspReady[1];

    assign reqReady[0] = bus0.req_ready;
    assign rspValid[0] = bus0.rsp_valid;
    assign rspRdata[0] = bus0.rsp_rdata;
    assign rspErr[0]   = bus0.rsp_err;
    assign busyOut[0]  = busy0;
    assign reqReady[1] = bus1.req_ready;
    assign rspValid[1] = bus1.rsp_valid;
    assign rspRdata[1] = bus1.rsp_rdata;
    assign rspErr[1]   = bus1.rsp_err;
    assign busyOut[1]  = busy1;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave), .busy_o(busy0)
    );
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waitsOf(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compareCount++;
        if (act !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each request is one record with the edge its
    // response appears on; memory is a sparse map keyed per instance.
    int          edgeCnt = 0;
    bit          mInFlight   [2];
    int          mRespEdge   [2];
    logic [31:0] mExpData    [2];
    bit          mExpErr     [2];
    bit          mStorePend  [2];
    int          mStoreKey   [2];
    logic [31:0] mStoreData  [2];
    logic [31:0] memModel    [int];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) mInFlight[d] = 1'b0;
        end else begin
            edgeCnt++;
            for (int d = 0; d < 2; d++) begin
                if (mInFlight[d] && edgeCnt == mRespEdge[d] && mStorePend[d])
                    memModel[mStoreKey[d]] = mStoreData[d];
                if (mInFlight[d] && edgeCnt > mRespEdge[d]) begin
                    if (rspReady[d]) mInFlight[d] = 1'b0;
                end else if (!mInFlight[d] && reqValid[d]) begin
                    mInFlight[d]  = 1'b1;
                    mRespEdge[d]  = edgeCnt + 1 + waitsOf(d);
                    mExpErr[d]    = (reqAddr[d] % 4 != 0) || (reqAddr[d] >= 32'd4096);
                    mStorePend[d] = 1'b0;
                    mExpData[d]   = 32'h0;
                    mStoreKey[d]  = d * 2048 + int'(reqAddr[d] / 4);
                    if (!mExpErr[d]) begin
                        if (reqWrite[d]) begin
                            mStorePend[d] = 1'b1;
                            mStoreData[d] = reqWdata[d];
                        end else if (memModel.exists(mStoreKey[d])) begin
                            mExpData[d] = memModel[mStoreKey[d]];
                        end else begin
                            mExpData[d] = 32'hxxxx_xxxx;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        bit expValid;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                expValid = mInFlight[d] && (edgeCnt >= mRespEdge[d]);
                checkOutput($sformatf("dut%0d req_ready", d), 32'(reqReady[d]), 32'(!mInFlight[d]));
                checkOutput($sformatf("dut%0d busy", d), 32'(busyOut[d]), 32'(mInFlight[d]));
                checkOutput($sformatf("dut%0d rsp_valid", d), 32'(rspValid[d]), 32'(expValid));
                if (expValid) begin
                    checkOutput($sformatf("dut%0d rsp_err", d), 32'(rspErr[d]), 32'(mExpErr[d]));
                    if (!$isunknown(mExpData[d]))
                        checkOutput($sformatf("dut%0d rsp_rdata", d), rspRdata[d], mExpData[d]);
                end
            end
        end
    end

    int lastAccept;
    int releaseEdge;

    task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        bit rdy;
        bit accepted;
        reqWrite[d] = wr;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        reqValid[d] = 1'b1;
        accepted    = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            rdy = reqReady[d];
            @(negedge clk);
            if (rdy) accepted = 1'b1;
        end
        reqValid[d] = 1'b0;
        if (!accepted) checkOutput($sformatf("dut%0d accept_timeout", d), 32'd0, 32'd1);
        lastAccept = edgeCnt;
    endtask

    task automatic awaitResponse(input int d, input int hold, output int lat,
                                 output logic [31:0] rdata, output logic err);
        bit got;
        rspReady[d] = (hold == 0);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (rspValid[d]) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) checkOutput($sformatf("dut%0d rsp_timeout", d), 32'd0, 32'd1);
        lat   = edgeCnt - lastAccept;
        rdata = rspRdata[d];
        err   = rspErr[d];
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            rspReady[d] = 1'b1;
        end
        releaseEdge = edgeCnt;
    endtask

    task automatic doTxn(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
        applyStimulus(d, wr, addr, wdata);
        awaitResponse(d, 0, lat, rdata, err);
        @(negedge clk);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;

        for (int d = 0; d < 2; d++) begin
            reqValid[d] = 1'b0; reqWrite[d] = 1'b0; reqAddr[d] = '0;
            reqWdata[d] = '0;   rspReady[d] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("reset dut%0d req_ready", d), 32'(reqReady[d]), 32'd1);
            checkOutput($sformatf("reset dut%0d rsp_valid", d), 32'(rspValid[d]), 32'd0);
            checkOutput($sformatf("reset dut%0d busy", d), 32'(busyOut[d]), 32'd0);
            checkOutput($sformatf("reset dut%0d rsp_rdata", d), rspRdata[d], 32'h0);
            checkOutput($sformatf("reset dut%0d rsp_err", d), 32'(rspErr[d]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] store then load, 2 wait states");
        doTxn(1, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
        checkOutput("store latency", 32'(lat), 32'd3);
        checkOutput("store err", 32'(er), 32'd0);
        checkOutput("store rdata", rd, 32'h0);
        doTxn(1, 1'b0, 32'h10, 32'h0, lat, rd, er);
        checkOutput("load latency", 32'(lat), 32'd3);
        checkOutput("load rdata", rd, 32'hDEADBEEF);

        $display("[TB] zero wait states");
        doTxn(0, 1'b1, 32'h0, 32'h12345678, lat, rd, er);
        checkOutput("w0 store latency", 32'(lat), 32'd1);
        doTxn(0, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checkOutput("w0 load latency", 32'(lat), 32'd1);
        checkOutput("w0 load rdata", rd, 32'h12345678);

        $display("[TB] error responses and last valid word");
        doTxn(1, 1'b0, 32'h13, 32'h0, lat, rd, er);
        checkOutput("misaligned err", 32'(er), 32'd1);
        checkOutput("misaligned rdata", rd, 32'h0);
        doTxn(1, 1'b1, 32'h0, 32'hA5A5A5A5, lat, rd, er);
        doTxn(1, 1'b1, 32'h1000, 32'hBAD0BAD0, lat, rd, er);
        checkOutput("range err", 32'(er), 32'd1);
        doTxn(1, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checkOutput("range array unchanged", rd, 32'hA5A5A5A5);
        doTxn(1, 1'b1, 32'hFFC, 32'h0F0F0F0F, lat, rd, er);
        checkOutput("last word err", 32'(er), 32'd0);
        doTxn(0, 1'b1, 32'h2, 32'h99999999, lat, rd, er);
        checkOutput("w0 misaligned err", 32'(er), 32'd1);
        doTxn(0, 1'b0, 32'h0, 32'h0, lat, rd, er);
        checkOutput("w0 misaligned no write", rd, 32'h12345678);

        $display("[TB] backpressure and back-to-back accept");
        applyStimulus(1, 1'b0, 32'h10, 32'h0);
        awaitResponse(1, 5, lat, rd, er);
        checkOutput("bp rdata", rd, 32'hDEADBEEF);
        applyStimulus(1, 1'b0, 32'hFFC, 32'h0);
        checkOutput("bp next accept edge", 32'(lastAccept - releaseEdge), 32'd2);
        awaitResponse(1, 0, lat, rd, er);
        checkOutput("last word rdata", rd, 32'h0F0F0F0F);
        @(negedge clk);

        $display("[TB] input isolation during WAIT");
        doTxn(1, 1'b1, 32'h24, 32'h24242424, lat, rd, er);
        applyStimulus(1, 1'b1, 32'h20, 32'h77777777);
        reqAddr[1] = 32'h24; reqWdata[1] = 32'hFFFFFFFF; reqValid[1] = 1'b1;
        @(negedge clk);
        reqValid[1] = 1'b0;
        awaitResponse(1, 0, lat, rd, er);
        @(negedge clk);
        checkOutput("iso latency", 32'(lat), 32'd3);
        doTxn(1, 1'b0, 32'h20, 32'h0, lat, rd, er);
        checkOutput("iso latched data", rd, 32'h77777777);
        doTxn(1, 1'b0, 32'h24, 32'h0, lat, rd, er);
        checkOutput("iso other word", rd, 32'h24242424);

        $display("[TB] reset mid-WAIT drops pending store");
        doTxn(1, 1'b1, 32'h40, 32'hCAFEF00D, lat, rd, er);
        doTxn(1, 1'b0, 32'h10, 32'h0, lat, rd, er);
        applyStimulus(1, 1'b1, 32'h40, 32'h11111111);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset req_ready", 32'(reqReady[1]), 32'd1);
        checkOutput("midreset rsp_valid", 32'(rspValid[1]), 32'd0);
        checkOutput("midreset busy", 32'(busyOut[1]), 32'd0);
        checkOutput("midreset rsp_rdata", rspRdata[1], 32'h0);
        checkOutput("midreset rsp_err", 32'(rspErr[1]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        doTxn(1, 1'b0, 32'h40, 32'h0, lat, rd, er);
        checkOutput("dropped store", rd, 32'hCAFEF00D);

        $display("[TB] zero-wait streaming");
        for (int i = 0; i < 4; i++)
            doTxn(0, 1'b1, 32'h100 + 32'(i * 4), 32'h1000_0000 + 32'(i), lat, rd, er);
        for (int i = 0; i < 4; i++) begin
            doTxn(0, 1'b0, 32'h100 + 32'(i * 4), 32'h0, lat, rd, er);
            checkOutput($sformatf("stream rdata %0d", i), rd, 32'h1000_0000 + 32'(i));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    initial begin
        #200000;
        mismatchCount++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
